// File: rtl/vc_input_buffer_pkg.sv
// Shared defaults and index-width helper for the per-port VC input buffer.
package vc_input_buffer_pkg;
  localparam int VC_NUM_DEF     = 4;
  localparam int FLIT_WIDTH_DEF = 32;

  // Width of a binary index into n entries; never narrower than one bit.
  function automatic int log2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vc_fifo_ctrl.sv
// Per-VC FIFO bookkeeping: pointers, occupancy, downstream credit and request.
module vc_fifo_ctrl
  import vc_input_buffer_pkg::*;
#(
  parameter int BUFF_DEPTH  = 4,
  parameter int DOWN_CREDIT = 4,
  parameter int PTR_W       = log2(BUFF_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic             pop,
  input  logic             credit_in,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             full,
  output logic             request
);
  localparam int CNT_W = $clog2(BUFF_DEPTH + 1);
  localparam int CRD_W = $clog2(DOWN_CREDIT + 1);

  logic [CNT_W-1:0] count;
  logic [CRD_W-1:0] credit;
  logic             wr_ok;

  assign full    = (count == CNT_W'(BUFF_DEPTH));
  assign request = (count != '0) && (credit != '0);
  assign wr_ok   = write && !full;

  // pop is only asserted by the top for a requesting VC, so it is trusted here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      credit <= CRD_W'(DOWN_CREDIT);
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop)      count <= count + 1'b1;
      else if (pop && !wr_ok) count <= count - 1'b1;
      // Returned credit beyond the downstream depth is ignored.
      if (credit_in && !pop && credit != CRD_W'(DOWN_CREDIT)) credit <= credit + 1'b1;
      else if (pop && !credit_in)                             credit <= credit - 1'b1;
    end
  end
endmodule

// File: rtl/vc_input_buffer.sv
// Input-port VC buffer: shared flit storage, per-VC FIFO control, registered
// pop output with credit return, and sticky error flags.
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int VC_NUM       = VC_NUM_DEF,
  parameter int VC_BCD_WIDTH = log2(VC_NUM),
  parameter int BUFF_DEPTH   = 4,
  parameter int FLIT_WIDTH   = FLIT_WIDTH_DEF,
  parameter int DOWN_CREDIT  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FLIT_WIDTH-1:0]   flit_in,
  input  logic                    flit_in_we,
  input  logic [VC_BCD_WIDTH-1:0] wr_vc,
  output logic [VC_NUM-1:0]       request,
  input  logic [VC_BCD_WIDTH-1:0] grant,
  input  logic                    any_grant,
  output logic [FLIT_WIDTH-1:0]   flit_out,
  output logic                    flit_out_valid,
  output logic [VC_BCD_WIDTH-1:0] flit_out_vc,
  input  logic [VC_NUM-1:0]       credit_in,
  output logic [VC_NUM-1:0]       credit_out,
  output logic                    err_overflow,
  output logic                    err_bad_grant
);
  localparam int PTR_W  = log2(BUFF_DEPTH);
  localparam int ADDR_W = VC_BCD_WIDTH + PTR_W;

  logic [VC_NUM-1:0][PTR_W-1:0] rd_ptr, wr_ptr;
  logic [VC_NUM-1:0]            full, wr_sel, pop_sel;
  logic [FLIT_WIDTH-1:0]        mem [0:VC_NUM*BUFF_DEPTH-1];
  logic                         pop_ok, wr_ok;
  logic [ADDR_W-1:0]            wr_addr, rd_addr;

  assign pop_ok  = any_grant && request[grant];
  assign wr_ok   = flit_in_we && !full[wr_vc];
  assign wr_addr = {wr_vc, wr_ptr[wr_vc]};
  assign rd_addr = {grant, rd_ptr[grant]};

  for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
    assign wr_sel[i]  = flit_in_we && (wr_vc == VC_BCD_WIDTH'(i));
    assign pop_sel[i] = pop_ok && (grant == VC_BCD_WIDTH'(i));

    vc_fifo_ctrl #(
      .BUFF_DEPTH (BUFF_DEPTH),
      .DOWN_CREDIT(DOWN_CREDIT),
      .PTR_W      (PTR_W)
    ) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .write    (wr_sel[i]),
      .pop      (pop_sel[i]),
      .credit_in(credit_in[i]),
      .rd_ptr   (rd_ptr[i]),
      .wr_ptr   (wr_ptr[i]),
      .full     (full[i]),
      .request  (request[i])
    );
  end

  // Storage is not reset; pointer reset alone discards buffered flits.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= flit_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_out       <= '0;
      flit_out_valid <= 1'b0;
      flit_out_vc    <= '0;
      credit_out     <= '0;
      err_overflow   <= 1'b0;
      err_bad_grant  <= 1'b0;
    end else begin
      flit_out_valid <= pop_ok;
      credit_out     <= pop_sel;
      if (pop_ok) begin
        flit_out    <= mem[rd_addr];
        flit_out_vc <= grant;
      end
      if (flit_in_we && full[wr_vc])        err_overflow  <= 1'b1;
      if (any_grant && !request[grant])     err_bad_grant <= 1'b1;
    end
  end
endmodule
